// File: rtl/fpu_dram_pkg.sv
// rtl/fpu_dram_pkg.sv - shared constants and state encoding for the FPU-to-DRAM bridge
package fpu_dram_pkg;

    localparam int LINE_BYTES     = 64;
    localparam int BEAT_BYTES     = 8;
    localparam int BEATS_PER_LINE = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_WAIT    = 3'd1,
        WR_BEATS   = 3'd2,
        RD_ISSUE   = 3'd3,
        RD_PRESENT = 3'd4,
        DONE       = 3'd5
    } state_t;

endpackage

// File: rtl/fpu_line_assembler.sv
// rtl/fpu_line_assembler.sv - collects returned 64-bit read beats into one 512-bit line
module fpu_line_assembler
    import fpu_dram_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         beat_valid,
    input  logic [63:0]  beat_data,
    output logic [3:0]   beat_cnt,
    output logic [511:0] line_data
);

    logic [3:0]   cnt_q, cnt_d;
    logic [511:0] line_q, line_d;
    logic [2:0]   slot;

    // Clearing only rewinds the counter so the presented line stays visible until overwritten.
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        slot   = 3'd7 - cnt_q[2:0];
        if (clear) begin
            cnt_d = '0;
        end else if (beat_valid && (cnt_q < 4'(BEATS_PER_LINE))) begin
            line_d[{slot, 6'b0} +: 64] = beat_data;
            cnt_d                      = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign beat_cnt  = cnt_q;
    assign line_data = line_q;

endmodule

// File: rtl/fpu_dram_bridge.sv
// rtl/fpu_dram_bridge.sv - FPU line to DRAM beat bridge; BRIDGE_STATS_EN adds line counters
module fpu_dram_bridge
    import fpu_dram_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  request,
    input  logic                  rd_wr,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [15:0]           request_size,
    input  logic                  fpu_ready,
    input  logic [511:0]          write_data,
    output logic                  dram_ready,
    output logic                  request_done,
    output logic [511:0]          read_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [63:0]           mem_wdata,
    input  logic                  mem_stall,
    input  logic [63:0]           mem_rdata,
    input  logic                  mem_rvalid
`ifdef BRIDGE_STATS_EN
    ,
    output logic [31:0]           stat_lines_wr,
    output logic [31:0]           stat_lines_rd
`endif
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [15:0]           size_q, size_d;
    logic [15:0]           line_cnt_q, line_cnt_d;
    logic [3:0]            beat_q, beat_d;
    logic [3:0]            outst_q, outst_d;
    logic [511:0]          wline_q, wline_d;

    logic                  last_line;
    logic                  issue_ok;
    logic                  rvalid_ok;
    logic                  asm_clear;
    logic [3:0]            asm_cnt;
    logic [ADDR_WIDTH-1:0] beat_addr;

    assign last_line = (line_cnt_q + 16'd1) == size_q;
    assign beat_addr = base_q
                     + ADDR_WIDTH'(line_cnt_q) * ADDR_WIDTH'(LINE_BYTES)
                     + ADDR_WIDTH'(beat_q[2:0]) * ADDR_WIDTH'(BEAT_BYTES);

    // beat_q is the write beat index in WR_BEATS and the count of issued reads in RD_ISSUE.
    assign mem_wr_en    = (state_q == WR_BEATS);
    assign mem_rd_en    = (state_q == RD_ISSUE) && !beat_q[3];
    assign mem_addr     = (mem_wr_en || mem_rd_en) ? beat_addr : '0;
    assign mem_wdata    = mem_wr_en ? wline_q[{~beat_q[2:0], 6'b0} +: 64] : '0;
    assign dram_ready   = (state_q == WR_WAIT) || (state_q == RD_PRESENT);
    assign request_done = (state_q == DONE);

    assign issue_ok  = mem_rd_en && !mem_stall;
    assign rvalid_ok = mem_rvalid && (outst_q != 4'd0);
    assign asm_clear = (state_q == IDLE) || (state_q == RD_PRESENT);

    fpu_line_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .beat_valid (rvalid_ok),
        .beat_data  (mem_rdata),
        .beat_cnt   (asm_cnt),
        .line_data  (read_data)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        size_d     = size_q;
        line_cnt_d = line_cnt_q;
        beat_d     = beat_q;
        wline_d    = wline_q;
        outst_d    = outst_q + {3'b000, issue_ok} - {3'b000, rvalid_ok};
        case (state_q)
            IDLE: begin
                if (request) begin
                    base_d     = address & ~ADDR_WIDTH'(BEAT_BYTES - 1);
                    size_d     = request_size;
                    line_cnt_d = '0;
                    beat_d     = '0;
                    if (request_size == 16'd0) state_d = DONE;
                    else if (rd_wr)            state_d = WR_WAIT;
                    else                       state_d = RD_ISSUE;
                end
            end
            WR_WAIT: begin
                if (fpu_ready) begin
                    wline_d = write_data;
                    beat_d  = '0;
                    state_d = WR_BEATS;
                end
            end
            WR_BEATS: begin
                if (!mem_stall) begin
                    beat_d = beat_q + 4'd1;
                    if (beat_q[2:0] == 3'd7) begin
                        line_cnt_d = line_cnt_q + 16'd1;
                        state_d    = last_line ? DONE : WR_WAIT;
                    end
                end
            end
            RD_ISSUE: begin
                if (issue_ok) beat_d = beat_q + 4'd1;
                if ((asm_cnt == 4'(BEATS_PER_LINE)) && fpu_ready) state_d = RD_PRESENT;
            end
            RD_PRESENT: begin
                line_cnt_d = line_cnt_q + 16'd1;
                beat_d     = '0;
                state_d    = last_line ? DONE : RD_ISSUE;
            end
            DONE: begin
                if (fpu_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            size_q     <= '0;
            line_cnt_q <= '0;
            beat_q     <= '0;
            outst_q    <= '0;
            wline_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            size_q     <= size_d;
            line_cnt_q <= line_cnt_d;
            beat_q     <= beat_d;
            outst_q    <= outst_d;
            wline_q    <= wline_d;
        end
    end

`ifdef BRIDGE_STATS_EN
    logic [31:0] stat_lines_wr_q, stat_lines_wr_d;
    logic [31:0] stat_lines_rd_q, stat_lines_rd_d;

    always_comb begin
        stat_lines_wr_d = stat_lines_wr_q;
        stat_lines_rd_d = stat_lines_rd_q;
        if (mem_wr_en && !mem_stall && (beat_q[2:0] == 3'd7) && (stat_lines_wr_q != '1))
            stat_lines_wr_d = stat_lines_wr_q + 32'd1;
        if ((state_q == RD_PRESENT) && (stat_lines_rd_q != '1))
            stat_lines_rd_d = stat_lines_rd_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lines_wr_q <= '0;
            stat_lines_rd_q <= '0;
        end else begin
            stat_lines_wr_q <= stat_lines_wr_d;
            stat_lines_rd_q <= stat_lines_rd_d;
        end
    end

    assign stat_lines_wr = stat_lines_wr_q;
    assign stat_lines_rd = stat_lines_rd_q;
`endif

endmodule

// File: tb/tb_fpu_dram_bridge.sv
// tb/tb_fpu_dram_bridge.sv - directed self-checking bench for fpu_dram_bridge
module tb_fpu_dram_bridge;

    logic         clk = 1'b0;
    logic         rst, request, rd_wr, fpu_ready, mem_stall, mem_rvalid;
    logic [31:0]  address, mem_addr;
    logic [15:0]  request_size;
    logic [511:0] write_data, read_data;
    logic         dram_ready, request_done, mem_wr_en, mem_rd_en;
    logic [63:0]  mem_wdata, mem_rdata;
`ifdef BRIDGE_STATS_EN
    logic [31:0]  stat_lines_wr, stat_lines_rd;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]   mem [0:8191];
    int           cyc, wr_cnt, rd_cnt, strobe_cnt, both_cnt;
    int           stall_pct, lat;
    bit           spurious;
    logic [31:0]  wr_addr_log[$];
    logic [511:0] rd_lines[$];

    typedef struct {
        logic [31:0] a;
        int          due;
    } rd_t;
    rd_t rq[$];

    always #5 clk = ~clk;

    fpu_dram_bridge #(.ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .request      (request),
        .rd_wr        (rd_wr),
        .address      (address),
        .request_size (request_size),
        .fpu_ready    (fpu_ready),
        .write_data   (write_data),
        .dram_ready   (dram_ready),
        .request_done (request_done),
        .read_data    (read_data),
        .mem_addr     (mem_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_en    (mem_rd_en),
        .mem_wdata    (mem_wdata),
        .mem_stall    (mem_stall),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid)
`ifdef BRIDGE_STATS_EN
        ,
        .stat_lines_wr(stat_lines_wr),
        .stat_lines_rd(stat_lines_rd)
`endif
    );

    function automatic logic [7:0] wbyte(input int seed, input int ln, input int i);
        return 8'((seed * 37 + ln * 13 + i * 7 + 3) & 255);
    endfunction

    function automatic logic [511:0] make_line(input int seed, input int ln);
        logic [511:0] l;
        for (int i = 0; i < 64; i++) l[511 - 8*i -: 8] = wbyte(seed, ln, i);
        return l;
    endfunction

    function automatic logic [7:0] pre_byte(input int a);
        return 8'((a * 5 + 17) & 255);
    endfunction

    function automatic logic [511:0] exp_rd_line(input int a);
        logic [511:0] l;
        for (int i = 0; i < 64; i++) l[511 - 8*i -: 8] = pre_byte(a + i);
        return l;
    endfunction

    function automatic logic [63:0] beat_at(input logic [31:0] a);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[63 - 8*j -: 8] = mem[13'(a + 32'(j))];
        return r;
    endfunction

    task automatic mem_model();
        forever begin
            @(negedge clk);
            cyc++;
            mem_stall = ($urandom_range(99) < stall_pct);
            if (rst) rq.delete();
            if (rq.size() != 0 && rq[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = beat_at(rq[0].a);
                void'(rq.pop_front());
            end else if (spurious && rq.size() == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
                spurious   = 1'b0;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
            #1;
            if (mem_wr_en || mem_rd_en) strobe_cnt++;
            if (mem_wr_en && mem_rd_en) both_cnt++;
            if (mem_wr_en && !mem_stall && !rst) begin
                wr_cnt++;
                wr_addr_log.push_back(mem_addr);
                for (int j = 0; j < 8; j++) mem[13'(mem_addr + 32'(j))] = mem_wdata[63 - 8*j -: 8];
            end
            if (mem_rd_en && !mem_stall && !rst) begin
                rd_cnt++;
                rq.push_back('{a: mem_addr, due: cyc + lat});
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic start_req(input logic rw, input logic [31:0] a, input logic [15:0] sz);
        @(negedge clk); #2;
        request = 1'b1; rd_wr = rw; address = a; request_size = sz;
        @(negedge clk); #2;
        request = 1'b0;
    endtask

    task automatic drive_write(input int n, input int seed, input bit inject, output bit ok);
        int lines = 0;
        for (int g = 0; g < 4000 && lines < n; g++) begin
            @(negedge clk); #2;
            if (inject) begin
                request = (g == 20); rd_wr = 1'b0; address = '0; request_size = 16'd1;
            end
            if (dram_ready) begin
                write_data = make_line(seed, lines);
                fpu_ready  = 1'b1;
                @(posedge clk); #1;
                fpu_ready  = 1'b0;
                request    = 1'b0;
                lines++;
            end
        end
        request = 1'b0;
        ok = (lines == n);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int g = 0; g < 4000 && !ok; g++) begin
            @(negedge clk); #2;
            if (request_done) ok = 1'b1;
        end
    endtask

    task automatic release_done();
        fpu_ready = 1'b1;
        @(posedge clk); #1;
        fpu_ready = 1'b0;
    endtask

    task automatic drive_read(input int hold, input int spur_at, output int pulses,
                              output bit done_ok, output bit stable_ok);
        pulses = 0; done_ok = 1'b0; stable_ok = 1'b1;
        rd_lines.delete();
        for (int g = 0; g < 4000 && !done_ok; g++) begin
            @(negedge clk); #2;
            if (g == spur_at) spurious = 1'b1;
            if (dram_ready) begin
                pulses++;
                rd_lines.push_back(read_data);
            end
            if (request_done) begin
                done_ok = 1'b1;
                if (rd_lines.size() == 0 || read_data !== rd_lines[$]) stable_ok = 1'b0;
            end
            fpu_ready = (g >= hold);
        end
        fpu_ready = 1'b1;
        @(posedge clk); #1;
        fpu_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        checks++;
        if ({dram_ready, request_done, mem_wr_en, mem_rd_en} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {dram_ready, request_done, mem_wr_en, mem_rd_en});
        end
        checks++;
        if (mem_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 0", mem_addr);
        end
        checks++;
        if (mem_wdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_wdata: got %h expected 0", mem_wdata);
        end
        checks++;
        if (read_data !== 512'd0) begin
            errors++;
            $display("FAIL reset_rdata: got nonzero expected 0");
        end
        rst = 1'b0;
    endtask

    task automatic test_write_two_lines();
        bit ok, dok;
        int bad;
        stall_pct = 0;
        wr_addr_log.delete();
        start_req(1'b1, 32'h0000_0BB8, 16'd2);
        drive_write(2, 1, 1'b0, ok);
        wait_done(dok);
        checks++;
        if (!(ok && dok)) begin
            errors++;
            $display("FAIL write2_done: got lines_ok=%0d done=%0d expected 1 1", ok, dok);
        end
        checks++;
        if (wr_addr_log.size() != 16) begin
            errors++;
            $display("FAIL write2_count: got %0d expected 16", wr_addr_log.size());
        end
        bad = 0;
        for (int k = 0; k < 16; k++)
            if (wr_addr_log[k] !== 32'h0BB8 + 32'(8 * k)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL write2_addr: got %0d wrong addresses expected 0", bad);
        end
        bad = 0;
        for (int ln = 0; ln < 2; ln++)
            for (int i = 0; i < 64; i++)
                if (mem[13'(32'h0BB8 + 32'(64 * ln + i))] !== wbyte(1, ln, i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL write2_data: got %0d wrong bytes expected 0", bad);
        end
        release_done();
        @(negedge clk); #2;
        checks++;
        if (request_done !== 1'b0) begin
            errors++;
            $display("FAIL write2_idle: got request_done=%b expected 0", request_done);
        end
    endtask

    task automatic test_read_latency3();
        int p, r0;
        bit d, s;
        stall_pct = 0; lat = 3; r0 = rd_cnt;
        start_req(1'b0, 32'h0, 16'd1);
        drive_read(0, -1, p, d, s);
        checks++;
        if (!d) begin
            errors++;
            $display("FAIL read1_done: got 0 expected 1");
        end
        checks++;
        if (p != 1) begin
            errors++;
            $display("FAIL read1_pulse: got %0d cycles expected 1", p);
        end
        checks++;
        if (rd_lines.size() == 0 || rd_lines[0] !== exp_rd_line(0)) begin
            errors++;
            $display("FAIL read1_data: got %h expected %h", read_data, exp_rd_line(0));
        end
        checks++;
        if (!s) begin
            errors++;
            $display("FAIL read1_stable: got changed read_data expected stable");
        end
        checks++;
        if (rd_cnt - r0 != 8) begin
            errors++;
            $display("FAIL read1_strobes: got %0d expected 8", rd_cnt - r0);
        end
    endtask

    task automatic test_read_stall_spurious();
        int p;
        bit d, s;
        stall_pct = 30; lat = 1;
        start_req(1'b0, 32'h0000_0043, 16'd2);
        drive_read(30, 25, p, d, s);
        stall_pct = 0;
        checks++;
        if (!d || p != 2) begin
            errors++;
            $display("FAIL read2_pulses: got done=%0d pulses=%0d expected 1 2", d, p);
        end
        checks++;
        if (rd_lines.size() < 1 || rd_lines[0] !== exp_rd_line(32'h40)) begin
            errors++;
            $display("FAIL read2_line0: got mismatched line expected bytes from 0x40");
        end
        checks++;
        if (rd_lines.size() < 2 || rd_lines[1] !== exp_rd_line(32'h80)) begin
            errors++;
            $display("FAIL read2_line1: got mismatched line expected bytes from 0x80");
        end
    endtask

    task automatic test_zero_size();
        int s0;
        fpu_ready = 1'b0; s0 = strobe_cnt;
        start_req(1'b1, 32'h0000_0100, 16'd0);
        @(negedge clk); #2;
        checks++;
        if (request_done !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: got %b expected 1", request_done);
        end
        checks++;
        if (strobe_cnt != s0) begin
            errors++;
            $display("FAIL zero_strobes: got %0d expected 0", strobe_cnt - s0);
        end
        release_done();
    endtask

    task automatic test_stall_write();
        bit ok, dok;
        int bad, c0;
        stall_pct = 50; c0 = wr_cnt;
        wr_addr_log.delete();
        start_req(1'b1, 32'h0000_1005, 16'd8);
        drive_write(8, 2, 1'b1, ok);
        wait_done(dok);
        stall_pct = 0;
        checks++;
        if (!(ok && dok)) begin
            errors++;
            $display("FAIL stall_done: got lines_ok=%0d done=%0d expected 1 1", ok, dok);
        end
        checks++;
        if (wr_cnt - c0 != 64) begin
            errors++;
            $display("FAIL stall_count: got %0d expected 64", wr_cnt - c0);
        end
        bad = 0;
        for (int k = 0; k < 64; k++)
            if (wr_addr_log[k] !== 32'h1000 + 32'(8 * k)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_addr: got %0d wrong addresses expected 0", bad);
        end
        bad = 0;
        for (int ln = 0; ln < 8; ln++)
            for (int i = 0; i < 64; i++)
                if (mem[13'(32'h1000 + 32'(64 * ln + i))] !== wbyte(2, ln, i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_image: got %0d wrong bytes expected 0", bad);
        end
        release_done();
    endtask

    task automatic test_reset_mid_write();
        bit ok, found, d, s;
        int snap, p;
        stall_pct = 0; found = 1'b0;
        start_req(1'b1, 32'h0000_0200, 16'd1);
        drive_write(1, 3, 1'b0, ok);
        for (int g = 0; g < 100 && !found; g++) begin
            if (mem_wr_en && mem_addr == 32'h0220) found = 1'b1;
            else begin @(negedge clk); #2; end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rstmid_beat4: got not reached expected beat 4 strobe");
        end
        checks++;
        if ({dram_ready, request_done, mem_wr_en, mem_rd_en} !== 4'b0000 || mem_addr !== 32'd0 || mem_wdata !== 64'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got ctrl=%b addr=%h wdata=%h expected 0", {dram_ready, request_done, mem_wr_en, mem_rd_en}, mem_addr, mem_wdata);
        end
        checks++;
        if (read_data !== 512'd0) begin
            errors++;
            $display("FAIL rstmid_rdata: got nonzero expected 0");
        end
        snap = strobe_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (strobe_cnt != snap) begin
            errors++;
            $display("FAIL rstmid_strobes: got %0d expected 0", strobe_cnt - snap);
        end
        lat = 2;
        start_req(1'b0, 32'h0000_0080, 16'd1);
        drive_read(0, -1, p, d, s);
        checks++;
        if (!d || p != 1 || rd_lines.size() < 1 || rd_lines[0] !== exp_rd_line(32'h80)) begin
            errors++;
            $display("FAIL rstmid_read: got done=%0d pulses=%0d expected 1 1 with bytes from 0x80", d, p);
        end
    endtask

`ifdef BRIDGE_STATS_EN
    task automatic test_stats();
        bit ok, dok, d, s;
        int p;
        apply_reset();
        checks++;
        if (stat_lines_wr !== 32'd0 || stat_lines_rd !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset: got wr=%0d rd=%0d expected 0 0", stat_lines_wr, stat_lines_rd);
        end
        start_req(1'b1, 32'h0000_1800, 16'd3);
        drive_write(3, 4, 1'b0, ok);
        wait_done(dok);
        release_done();
        lat = 2;
        start_req(1'b0, 32'h0, 16'd2);
        drive_read(0, -1, p, d, s);
        checks++;
        if (stat_lines_wr !== 32'd3) begin
            errors++;
            $display("FAIL stats_wr: got %0d expected 3", stat_lines_wr);
        end
        checks++;
        if (stat_lines_rd !== 32'd2) begin
            errors++;
            $display("FAIL stats_rd: got %0d expected 2", stat_lines_rd);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; request = 1'b0; rd_wr = 1'b0; address = '0; request_size = '0;
        fpu_ready = 1'b0; write_data = '0;
        mem_stall = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        stall_pct = 0; lat = 1; spurious = 1'b0;
        cyc = 0; wr_cnt = 0; rd_cnt = 0; strobe_cnt = 0; both_cnt = 0;
        for (int i = 0; i < 8192; i++) mem[i] = pre_byte(i);
        fork
            mem_model();
        join_none
        test_reset();
        test_write_two_lines();
        test_read_latency3();
        test_read_stall_spurious();
        test_zero_size();
        test_stall_write();
        test_reset_mid_write();
`ifdef BRIDGE_STATS_EN
        test_stats();
`endif
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL exclusive_strobes: got %0d overlapping cycles expected 0", both_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_dram_bridge.md
FPU_DRAM_BRIDGE -- requirements
Module: fpu_dram_bridge

Interface
REQ-001 The block SHALL have one parameter: ADDR_WIDTH, default 32, the byte-address width on both sides.
REQ-002 The block SHALL have these ports (port, direction, width, meaning):
- clk  in  1  sole clock.
- rst  in  1  asynchronous active-high reset.
- request  in  1  FPU starts a transfer (single-cycle pulse).
- rd_wr  in  1  1 means write to memory, 0 means read.
- address  in  ADDR_WIDTH  start byte address.
- request_size  in  16  number of 64-byte lines.
- fpu_ready  in  1  FPU can send or accept a line.
- write_data  in  512  write line; byte i is at [511-8i -:8].
- dram_ready  out  1  line slot open (write) or read line valid.
- request_done  out  1  transfer complete.
- read_data  out  512  read line, same byte order as write_data.
- mem_addr  out  ADDR_WIDTH  beat address.
- mem_wr_en  out  1  write strobe.
- mem_rd_en  out  1  read strobe.
- mem_wdata  out  64  write beat; lowest-address byte is in [63:56].
- mem_stall  in  1  memory refuses the strobe this cycle.
- mem_rdata  in  64  returned beat.
- mem_rvalid  in  1  mem_rdata valid; beats return in order, latency 1 or more.

Function
REQ-003 States SHALL be IDLE, WR_WAIT, WR_BEATS, RD_ISSUE, RD_PRESENT and DONE.
REQ-004 In IDLE, request SHALL latch address (with [2:0] forced to 0), request_size and rd_wr, clear line_cnt, and go to WR_WAIT if rd_wr=1, else RD_ISSUE.
REQ-005 If request_size=0, the block SHALL go directly to DONE.
REQ-006 request SHALL be ignored outside IDLE.
REQ-007 WR_WAIT SHALL drive dram_ready=1; on fpu_ready=1 it SHALL capture write_data and go to WR_BEATS.
REQ-008 WR_BEATS SHALL issue 8 beats (k=0..7) with mem_addr = base + 64*line_cnt + 8k and mem_wdata = line[511-64k -:64].
REQ-009 A beat SHALL advance only in a cycle where mem_stall=0, and dram_ready SHALL be 0 throughout WR_BEATS.
REQ-010 After beat 7, line_cnt SHALL increment; the block SHALL return to WR_WAIT, or go to DONE if line_cnt = request_size.
REQ-011 RD_ISSUE SHALL issue 8 pipelined reads at the REQ-008 addresses, with no more than 8 outstanding.
REQ-012 Returned beat k SHALL be placed at read_data[511-64k -:64].
REQ-013 Once 8 beats have returned and fpu_ready=1, the block SHALL enter RD_PRESENT.
REQ-014 RD_PRESENT SHALL assert dram_ready for exactly 1 cycle with read_data stable, then increment line_cnt and go to RD_ISSUE, or to DONE when line_cnt = request_size.
REQ-015 DONE SHALL hold request_done=1 until a cycle with fpu_ready=1, then return to IDLE in the next cycle.
REQ-016 mem_wr_en and mem_rd_en SHALL never both be 1, and the block SHALL never assert either outside WR_BEATS or RD_ISSUE.
REQ-017 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-018 mem_rvalid arriving with no read outstanding SHALL be ignored.

Reset
REQ-019 rst SHALL immediately force IDLE and drive all outputs to 0, including read_data, and clear line_cnt and the outstanding-read count.
REQ-020 Reset mid-transfer SHALL abort the transfer with no further mem strobes, and the block SHALL drop mem_rvalid beats from the aborted transfer.

Configuration
REQ-021 When BRIDGE_STATS_EN is defined, the block SHALL add outputs stat_lines_wr[31:0] and stat_lines_rd[31:0].
REQ-022 The stat counters SHALL increment on each completed write line and each presented read line, saturate at all-ones, and be cleared by rst.
REQ-023 When BRIDGE_STATS_EN is undefined, those ports and their counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-024 Package fpu_dram_pkg SHALL hold the state enum and the constants LINE_BYTES=64, BEAT_BYTES=8 and BEATS_PER_LINE=8.
REQ-025 The read-beat assembly (beat counter plus 512-bit line register) SHALL be a sub-module named fpu_line_assembler.

Verification
REQ-026 Write of 2 lines at address 0x0BB8 with mem_stall=0: 16 mem writes to 0x0BB8..0x0C30 in steps of 8, bytes matching the reference, then request_done=1.
REQ-027 Read of 1 line at 0x0000 with mem_rvalid latency 3: dram_ready pulses exactly 1 cycle, read_data equals mem bytes 0..63 in order, then request_done.
REQ-028 Random mem_stall at 50% during an 8-line write: the block loses and duplicates no beats, and the final memory image equals the reference.
REQ-029 request_size=0: request_done=1 two cycles after request, with no mem strobes.
REQ-030 rst pulsed at beat 4 of a write: outputs go to 0 at once, no further strobes occur, and a new 1-line read afterwards completes correctly.
REQ-031 With BRIDGE_STATS_EN defined, 3 write lines then 2 read lines give stat_lines_wr=3 and stat_lines_rd=2.
